gated_charge_integrator: RTL and testbench



---
 rtl/gated_charge_integrator_if.sv | 25 ++
 rtl/gated_charge_integrator.sv | 196 +++++++++++++++++++
 tb/tb_gated_charge_integrator.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gated_charge_integrator_if.sv
// Sample/trigger inputs and event-result handshake for gated_charge_integrator.
interface gated_charge_integrator_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ACC_W  = 30
);
    logic [DATA_W-1:0]       data_in;
    logic                    trig_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_charge;
    logic [DATA_W-1:0]       out_peak;
    logic                    out_overflow;
    logic                    busy;
    logic                    trig_lost;

    // master: sample source + result consumer; slave: the integrator
    modport master (
        output data_in, trig_in, out_ready,
        input  out_valid, out_charge, out_peak, out_overflow, busy, trig_lost
    );
    modport slave (
        input  data_in, trig_in, out_ready,
        output out_valid, out_charge, out_peak, out_overflow, busy, trig_lost
    );
endinterface

// File: rtl/gated_charge_integrator.sv
// Per-trigger windowed integration of baseline-subtracted ADC samples, with pre-trigger
// delay line, peak tracking, saturating accumulator, result handshake and holdoff.
module gated_charge_integrator #(
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned ACC_W       = 30,
    parameter int unsigned PRE_SAMPLES = 4,
    parameter int unsigned GATE_LEN    = 32,
    parameter int unsigned BASE_LOG2   = 3,
    parameter int unsigned HOLDOFF     = 16,
    parameter bit          POLARITY    = 1'b0
) (
    input logic                      clk,
    input logic                      rst,
    gated_charge_integrator_if.slave bus
);
    localparam int unsigned S_W     = DATA_W + 1;
    localparam int unsigned SUM_W   = DATA_W + BASE_LOG2;
    localparam int unsigned BCNT_W  = (BASE_LOG2 > 0) ? BASE_LOG2 : 1;
    localparam int unsigned CNT_MAX = (GATE_LEN > HOLDOFF) ? GATE_LEN : HOLDOFF;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [BCNT_W-1:0]       BLK_LAST  = BCNT_W'((1 << BASE_LOG2) - 1);
    localparam logic [CNT_W-1:0]        GATE_LAST = CNT_W'(GATE_LEN - 1);
    localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_INTEG, S_OUTPUT, S_HOLDOFF} state_e;

    state_e                  state, state_d;
    logic [DATA_W-1:0]       dline [PRE_SAMPLES];
    logic [DATA_W-1:0]       d;
    logic                    trig_prev;
    logic                    edge_c;
    logic [DATA_W-1:0]       baseline, baseline_d;
    logic                    base_valid, base_valid_d;
    logic [SUM_W-1:0]        bsum, bsum_d, bsum_nx;
    logic [BCNT_W-1:0]       bcnt, bcnt_d;
    logic signed [ACC_W-1:0] acc, acc_d, acc_sat;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [S_W-1:0]   s;
    logic                    sat_hit;
    logic [DATA_W-1:0]       peak, peak_d, peak_nx;
    logic                    ovf, ovf_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_charge_q, out_charge_d;
    logic [DATA_W-1:0]       out_peak_q, out_peak_d;
    logic                    out_overflow_q, out_overflow_d;
    logic                    busy_q;
    logic                    trig_lost_q, trig_lost_d;

    // Pre-trigger delay line: d lags data_in by PRE_SAMPLES clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PRE_SAMPLES); i++) dline[i] <= '0;
        end else begin
            dline[0] <= bus.data_in;
            for (int i = 1; i < int'(PRE_SAMPLES); i++) dline[i] <= dline[i-1];
        end
    end

    assign d      = dline[PRE_SAMPLES-1];
    assign edge_c = bus.trig_in & ~trig_prev;

    // Baseline-subtracted sample, saturating add and running peak
    always_comb begin
        if (POLARITY) s = $signed({1'b0, baseline}) - $signed({1'b0, d});
        else          s = $signed({1'b0, d}) - $signed({1'b0, baseline});
        acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(s);
        sat_hit = acc_sum[ACC_W] != acc_sum[ACC_W-1];
        if (sat_hit) acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else         acc_sat = acc_sum[ACC_W-1:0];
        peak_nx = (!s[S_W-1] && (s[DATA_W-1:0] > peak)) ? s[DATA_W-1:0] : peak;
        bsum_nx = bsum + SUM_W'(d);
    end

    // Next-state and datapath update
    always_comb begin
        state_d        = state;
        baseline_d     = baseline;
        base_valid_d   = base_valid;
        bsum_d         = bsum;
        bcnt_d         = bcnt;
        acc_d          = acc;
        peak_d         = peak;
        ovf_d          = ovf;
        cnt_d          = cnt;
        out_valid_d    = out_valid_q;
        out_charge_d   = out_charge_q;
        out_peak_d     = out_peak_q;
        out_overflow_d = out_overflow_q;
        trig_lost_d    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bcnt == BLK_LAST) begin
                    baseline_d   = DATA_W'(bsum_nx >> BASE_LOG2);
                    base_valid_d = 1'b1;
                    bsum_d       = '0;
                    bcnt_d       = '0;
                end else begin
                    bsum_d = bsum_nx;
                    bcnt_d = bcnt + BCNT_W'(1);
                end
                if (edge_c) begin
                    if (base_valid) begin
                        state_d = S_INTEG;
                        acc_d   = '0;
                        peak_d  = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                        // partial baseline block is discarded on leaving IDLE
                        bsum_d  = '0;
                        bcnt_d  = '0;
                    end else begin
                        trig_lost_d = 1'b1;
                    end
                end
            end
            S_INTEG: begin
                trig_lost_d = edge_c;
                acc_d       = acc_sat;
                peak_d      = peak_nx;
                ovf_d       = ovf | sat_hit;
                cnt_d       = cnt + CNT_W'(1);
                if (cnt == GATE_LAST) begin
                    out_charge_d   = acc_sat;
                    out_peak_d     = peak_nx;
                    out_overflow_d = ovf | sat_hit;
                    out_valid_d    = 1'b1;
                    state_d        = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                trig_lost_d = edge_c;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                trig_lost_d = edge_c;
                cnt_d       = cnt + CNT_W'(1);
                if (cnt == HOLD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            trig_prev      <= 1'b0;
            baseline       <= '0;
            base_valid     <= 1'b0;
            bsum           <= '0;
            bcnt           <= '0;
            acc            <= '0;
            peak           <= '0;
            ovf            <= 1'b0;
            cnt            <= '0;
            out_valid_q    <= 1'b0;
            out_charge_q   <= '0;
            out_peak_q     <= '0;
            out_overflow_q <= 1'b0;
            busy_q         <= 1'b0;
            trig_lost_q    <= 1'b0;
        end else begin
            state          <= state_d;
            trig_prev      <= bus.trig_in;
            baseline       <= baseline_d;
            base_valid     <= base_valid_d;
            bsum           <= bsum_d;
            bcnt           <= bcnt_d;
            acc            <= acc_d;
            peak           <= peak_d;
            ovf            <= ovf_d;
            cnt            <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_charge_q   <= out_charge_d;
            out_peak_q     <= out_peak_d;
            out_overflow_q <= out_overflow_d;
            busy_q         <= (state_d != S_IDLE);
            trig_lost_q    <= trig_lost_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_charge   = out_charge_q;
    assign bus.out_peak     = out_peak_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.busy         = busy_q;
    assign bus.trig_lost    = trig_lost_q;
endmodule

// File: tb/tb_gated_charge_integrator.sv
// Bench for gated_charge_integrator: directed scenarios on three parameterisations plus
// randomized events on the default build checked against an event-level reference model.
module tb_gated_charge_integrator;
    localparam int PRE     = 4;
    localparam int GATE    = 32;
    localparam int BLK     = 8;
    localparam int HOLD    = 16;
    localparam int HIST_N  = 4096;
    localparam longint A30_MAX = (longint'(1) << 29) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hist [HIST_N];

    gated_charge_integrator_if #(.DATA_W(14), .ACC_W(30)) if0 ();
    gated_charge_integrator_if #(.DATA_W(14), .ACC_W(30)) if1 ();
    gated_charge_integrator_if #(.DATA_W(14), .ACC_W(16)) if2 ();

    gated_charge_integrator u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    gated_charge_integrator #(.POLARITY(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    gated_charge_integrator #(.ACC_W(16)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: record the sample u0 takes at this edge, then move off the edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (cyc < HIST_N) hist[cyc] = int'(if0.data_in);
        #1;
    endtask

    task automatic idle_inputs();
        if0.data_in = '0; if0.trig_in = 1'b0; if0.out_ready = 1'b0;
        if1.data_in = '0; if1.trig_in = 1'b0; if1.out_ready = 1'b0;
        if2.data_in = '0; if2.trig_in = 1'b0; if2.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    // Delayed sample seen by u0 at posedge k (delay line is zero right after reset)
    function automatic int d_at(input int k);
        if (k - PRE >= 1 && k - PRE < HIST_N) return hist[k - PRE];
        return 0;
    endfunction

    // Mean of the n-th complete block of an IDLE period that began at posedge e
    function automatic int blk_avg(input int e, input int n);
        int sum = 0;
        for (int k = e + BLK * (n - 1); k < e + BLK * n; k++) sum += d_at(k);
        return sum / BLK;
    endfunction

    initial begin
        int  e_m, base_m, t, nb, spur, h, coin, wait_n;
        bit  bv_m, accepted, seen;
        longint acc_m;
        int  pk_m, sv;
        bit  ov_m;

        idle_inputs();

        // Default build: reset state, basic event, stall, holdoff
        do_reset();
        check("rst_valid", if0.out_valid, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_charge", $signed(if0.out_charge), 0);
        check("rst_lost", if0.trig_lost, 0);
        if0.data_in = 14'd100;
        repeat (20) tick();
        if0.trig_in = 1'b1; tick();                       // accepted edge at 21
        check("a_busy", if0.busy, 1);
        check("a_nolost", if0.trig_lost, 0);
        if0.trig_in = 1'b0; if0.data_in = 14'd300;
        repeat (4) tick();
        if0.data_in = 14'd100;
        while (cyc < 52) tick();
        check("a_valid_early", if0.out_valid, 0);
        tick();                                           // 53 = edge + 32
        check("a_valid", if0.out_valid, 1);
        check("a_charge", $signed(if0.out_charge), 800);
        check("a_peak", if0.out_peak, 200);
        check("a_ovf", if0.out_overflow, 0);
        while (cyc < 59) tick();
        check("a_lost_pre", if0.trig_lost, 0);
        if0.trig_in = 1'b1; tick();
        check("a_lost_pulse", if0.trig_lost, 1);
        if0.trig_in = 1'b0; tick();
        check("a_lost_end", if0.trig_lost, 0);
        while (cyc < 103) tick();
        check("a_stall_valid", if0.out_valid, 1);
        check("a_stall_charge", $signed(if0.out_charge), 800);
        check("a_stall_peak", if0.out_peak, 200);
        if0.out_ready = 1'b1; tick();                     // handshake at 104
        if0.out_ready = 1'b0;
        check("a_hs_valid", if0.out_valid, 0);
        check("a_hs_busy", if0.busy, 1);
        while (cyc < 119) tick();
        check("a_hold_busy", if0.busy, 1);
        tick();
        check("a_idle_busy", if0.busy, 0);
        check("a_keep_charge", $signed(if0.out_charge), 800);

        // Reset mid-integration, then early edge lost and later edge accepted
        while (cyc < 130) tick();
        if0.trig_in = 1'b1; tick();
        if0.trig_in = 1'b0;
        check("b_busy", if0.busy, 1);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("b_abort_busy", if0.busy, 0);
        check("b_abort_charge", $signed(if0.out_charge), 0);
        check("b_abort_peak", if0.out_peak, 0);
        check("b_abort_valid", if0.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        seen = 1'b0;
        repeat (2) tick();
        if0.trig_in = 1'b1; tick();                       // edge at 3, no baseline yet
        if0.trig_in = 1'b0;
        check("b_early_lost", if0.trig_lost, 1);
        check("b_early_busy", if0.busy, 0);
        while (cyc < 19) begin tick(); seen |= if0.out_valid; end
        if0.trig_in = 1'b1; tick();                       // edge at 20
        if0.trig_in = 1'b0;
        check("b_late_busy", if0.busy, 1);
        check("b_late_nolost", if0.trig_lost, 0);
        while (cyc < 51) begin
            if0.data_in = (cyc == 24) ? 14'd250 : 14'd100;
            tick();
            seen |= if0.out_valid;
        end
        check("b_no_stray_valid", seen, 0);
        tick();
        check("b_valid", if0.out_valid, 1);
        check("b_charge", $signed(if0.out_charge), 150);
        check("b_peak", if0.out_peak, 150);

        // Negative polarity and narrow-accumulator saturation builds
        do_reset();
        if1.data_in = 14'd1000;
        repeat (17) tick();
        if2.data_in = 14'd16383;
        repeat (3) tick();
        if1.trig_in = 1'b1; if2.trig_in = 1'b1; tick();   // edge at 21
        if1.trig_in = 1'b0; if2.trig_in = 1'b0;
        if1.data_in = 14'd400;
        repeat (3) tick();
        if1.data_in = 14'd1000;
        while (cyc < 52) tick();
        check("c_valid_early", if2.out_valid, 0);
        tick();
        check("c_pol_valid", if1.out_valid, 1);
        check("c_pol_charge", $signed(if1.out_charge), 1800);
        check("c_pol_peak", if1.out_peak, 600);
        check("c_pol_ovf", if1.out_overflow, 0);
        check("c_sat_valid", if2.out_valid, 1);
        check("c_sat_charge", $signed(if2.out_charge), 32767);
        check("c_sat_peak", if2.out_peak, 16383);
        check("c_sat_ovf", if2.out_overflow, 1);

        // Randomized events on the default build against the event-level model
        do_reset();
        e_m = 1; base_m = 0; bv_m = 1'b0;
        for (int ev = 0; ev < 14; ev++) begin
            repeat ($urandom_range(1, 25)) begin
                if0.data_in = 14'($urandom_range(0, 2000));
                tick();
            end
            t = cyc + 1;
            if0.trig_in = 1'b1; if0.data_in = 14'($urandom_range(0, 2000));
            tick();
            if0.trig_in = 1'b0;
            accepted = bv_m || ((t - e_m) / BLK > 0);
            check("r_edge_lost", if0.trig_lost, !accepted);
            check("r_edge_busy", if0.busy, accepted);
            if (!accepted) continue;
            nb = (t - e_m + 1) / BLK;
            if (nb > 0) base_m = blk_avg(e_m, nb);
            bv_m = 1'b1;
            spur = $urandom_range(2, GATE - 2);
            for (int j = 1; j <= GATE; j++) begin
                if ($urandom_range(0, 3) == 0) if0.data_in = 14'($urandom_range(0, 16383));
                else if0.data_in = 14'($urandom_range(0, 2000));
                if0.trig_in = (j == spur);
                tick();
                if (j == spur) check("r_spur_lost", if0.trig_lost, 1);
                if (j == GATE - 1) check("r_valid_early", if0.out_valid, 0);
            end
            if0.trig_in = 1'b0;
            acc_m = 0; pk_m = 0; ov_m = 1'b0;
            for (int k = t + 1; k <= t + GATE; k++) begin
                sv = d_at(k) - base_m;
                acc_m += sv;
                if (acc_m > A30_MAX) begin acc_m = A30_MAX; ov_m = 1'b1; end
                else if (acc_m < -A30_MAX - 1) begin acc_m = -A30_MAX - 1; ov_m = 1'b1; end
                if (sv > pk_m) pk_m = sv;
            end
            check("r_valid", if0.out_valid, 1);
            check("r_charge", $signed(if0.out_charge), acc_m);
            check("r_peak", if0.out_peak, pk_m);
            check("r_ovf", if0.out_overflow, ov_m);
            wait_n = $urandom_range(0, 4);
            repeat (wait_n) tick();
            check("r_hold_valid", if0.out_valid, 1);
            if0.out_ready = 1'b1; tick();
            if0.out_ready = 1'b0;
            h = cyc;
            check("r_hs_valid", if0.out_valid, 0);
            while (cyc < h + HOLD - 1) tick();
            check("r_hold_busy", if0.busy, 1);
            coin = $urandom_range(0, 1);
            if0.trig_in = coin[0]; tick();                // edge on the re-arm clock is lost
            if0.trig_in = 1'b0;
            check("r_rearm_busy", if0.busy, 0);
            check("r_rearm_lost", if0.trig_lost, coin[0]);
            e_m = h + HOLD + 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
